uart_transceiver: RTL
=====================

# uart_transceiver

8N1 asynchronous serial transceiver sitting directly downstream of the 68000 bus controller's UART ports (0x00100003 status, 0x00100005 send, 0x00100007 receive). It serializes bytes handed over by the send trigger onto TXD, deserializes RXD into a one-byte holding register, and reports the busy and received flags back to the bus controller. The bus controller's trigger and capture strobes are level signals held for a whole bus cycle; this block edge-detects them internally.

## Interface
- BAUD_DIV, 87: MCLK cycles per bit (10 MHz / 115200); legal range 4..65535.
- MCLK_IN  in  1  system clock; all state changes on rising edge.
- RESET_IN  in  1  asynchronous, active-high reset.
- UART_SEND_TRIGGER_IN  in  1  level; its rising edge requests transmission.
- UART_SEND_BYTE_IN  in  8  byte to send; valid while trigger is high.
- UART_RECEIVE_CAPTURE_IN  in  1  level; high while CPU reads the receive port.
- RXD_IN  in  1  serial input, asynchronous, idle high.
- TXD  out  1  serial output, idle high.
- UART_SEND_BUSY  out  1  transmitter busy.
- UART_RECEIVED  out  1  holding register contains an unread byte.
- UART_RECEIVE_BYTE  out  8  holding register.
- UART_OVERRUN  out  1  byte lost because holding register was full.

## Operation
- Reset values: TXD=1, UART_SEND_BUSY=0, UART_RECEIVED=0, UART_RECEIVE_BYTE=0, UART_OVERRUN=0; both FSMs in IDLE, edge detectors' history flops=0, RXD synchronizer flops=1.
- Transmitter FSM TX_IDLE -> TX_START -> TX_DATA (8 bits, LSB first) -> TX_STOP -> TX_IDLE.
  - TX_IDLE: on trigger rising edge (trigger=1, previous sample=0) latch byte, BUSY=1, enter TX_START.
  - Each state holds TXD for exactly BAUD_DIV cycles: START drives 0, DATA drives bit[n], STOP drives 1.
  - Trigger edges while BUSY=1 are ignored; latched byte is not altered.
- Receiver: RXD_IN passes a 2-flop synchronizer; FSM operates on the synchronized value.
  - RX_IDLE: synchronized RXD=0 -> RX_START, counter loaded with BAUD_DIV/2 (integer floor).
  - RX_START: at count end, if RXD still 0 -> RX_DATA; else false start -> RX_IDLE.
  - RX_DATA: sample every BAUD_DIV cycles, shift in LSB first; after 8 samples -> RX_STOP.
  - RX_STOP: sample after BAUD_DIV cycles. Stop=1 and RECEIVED=0: load holding register, RECEIVED=1. Stop=1 and RECEIVED=1: set OVERRUN, holding register unchanged. Stop=0: framing error, frame discarded, no flag change. Return to RX_IDLE in all cases.
- Capture: RECEIVED and OVERRUN clear on the falling edge of UART_RECEIVE_CAPTURE_IN, so the byte stays stable for the whole bus read.
- Simultaneous capture falling edge and good-stop completion: the clear takes effect first, the new byte loads, RECEIVED=1, OVERRUN=0.
- TX and RX run fully independently; loopback (TXD tied to RXD_IN) must work.

## Timing
- Trigger rising edge sampled at edge k: BUSY=1 and TXD=0 from edge k+1.
- Frame length is 10*BAUD_DIV cycles. BUSY falls at the end of the stop bit, edge k+1+10*BAUD_DIV. A new trigger is accepted at that edge or later.
- RX latency: the synchronizer adds 2 cycles. Data sampling occurs at BAUD_DIV/2 + n*BAUD_DIV cycles after the synchronized falling edge. RECEIVED rises 1 cycle after the stop-bit sample.
- Capture falling edge sampled at edge m: RECEIVED=0 from edge m+1.
- The bus controller updates its strobes on the MCLK falling edge, so inputs are stable a half-cycle before each rising edge. No additional synchronization is applied to strobe inputs.
- Reset mid-frame: TXD returns to 1 immediately (asynchronously). A partial RX frame is discarded.

## Structure
- Package uart_pkg: tx_state_t, rx_state_t enums; FRAME_DATA_BITS=8; default BAUD_DIV.
- Sub-module uart_bit_timer (load value, count-down, done pulse), instantiated once in TX and once in RX.
- The top level holds the edge detectors, synchronizer, both FSMs and the holding register.

## Test plan
- Reset, then idle 100 cycles -> TXD=1, all flags 0, byte 0x00.
- BAUD_DIV=4, trigger with 0xA5 -> TXD is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. BUSY is high for exactly 40 cycles.
- Second trigger with 0x3C mid-frame -> waveform and latched byte remain those of 0xA5. No second frame is sent.
- Loopback 0x5A, then capture pulse -> RECEIVED=1 with byte 0x5A before capture; RECEIVED=0 one cycle after capture falls.
- Receive 0x11 and then 0x22 without capture -> byte stays 0x11, OVERRUN=1. Capture clears both flags.
- A 1-cycle RXD low glitch produces no flag change (false start). A frame with stop bit 0 leaves RECEIVED=0. Reset asserted mid-TX drives TXD=1 and BUSY=0 immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transceiver.
package uart_pkg;

    localparam int FRAME_DATA_BITS  = 8;
    localparam int DEFAULT_BAUD_DIV = 87;   // 10 MHz / 115200
    localparam int TIMER_W          = 16;   // holds BAUD_DIV up to 65535

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_if.sv
// Bus-controller strobes, serial lines and status flags of the UART.
interface uart_if;
    import uart_pkg::*;

    logic                       UART_SEND_TRIGGER_IN;
    logic [FRAME_DATA_BITS-1:0] UART_SEND_BYTE_IN;
    logic                       UART_RECEIVE_CAPTURE_IN;
    logic                       RXD_IN;
    logic                       TXD;
    logic                       UART_SEND_BUSY;
    logic                       UART_RECEIVED;
    logic [FRAME_DATA_BITS-1:0] UART_RECEIVE_BYTE;
    logic                       UART_OVERRUN;

    // Bus controller / line side
    modport master (
        output UART_SEND_TRIGGER_IN, UART_SEND_BYTE_IN, UART_RECEIVE_CAPTURE_IN, RXD_IN,
        input  TXD, UART_SEND_BUSY, UART_RECEIVED, UART_RECEIVE_BYTE, UART_OVERRUN
    );

    // Transceiver side
    modport slave (
        input  UART_SEND_TRIGGER_IN, UART_SEND_BYTE_IN, UART_RECEIVE_CAPTURE_IN, RXD_IN,
        output TXD, UART_SEND_BUSY, UART_RECEIVED, UART_RECEIVE_BYTE, UART_OVERRUN
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; done pulses for one cycle, load_val cycles after load.
module uart_bit_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // Count down to zero after a load; a load always wins over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // Done when the last cycle of the interval is running, so the owner can
    // change state (and reload) exactly load_val edges after the load.
    assign done = (cnt == W'(1));

endmodule

// File: rtl/uart_transceiver.sv
// 8N1 transmitter and receiver with bus-strobe edge detection and a
// one-byte receive holding register.
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = DEFAULT_BAUD_DIV
) (
    input  logic MCLK_IN,
    input  logic RESET_IN,
    uart_if.slave bus
);

    localparam logic [TIMER_W-1:0] BIT_TICKS  = TIMER_W'(BAUD_DIV);
    localparam logic [TIMER_W-1:0] HALF_TICKS = TIMER_W'(BAUD_DIV / 2);
    localparam logic [2:0]         LAST_BIT   = 3'(FRAME_DATA_BITS - 1);

    // ---------------- strobe edge detectors ----------------
    logic trig_q, cap_q;
    logic trig_rise, cap_fall;

    // History flops for the level strobes from the bus controller.
    always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            trig_q <= 1'b0;
            cap_q  <= 1'b0;
        end else begin
            trig_q <= bus.UART_SEND_TRIGGER_IN;
            cap_q  <= bus.UART_RECEIVE_CAPTURE_IN;
        end
    end

    assign trig_rise = bus.UART_SEND_TRIGGER_IN & ~trig_q;
    assign cap_fall  = cap_q & ~bus.UART_RECEIVE_CAPTURE_IN;

    // ---------------- transmitter ----------------
    tx_state_t                  tx_state, tx_state_n;
    logic [FRAME_DATA_BITS-1:0] tx_sh, tx_sh_n;
    logic [2:0]                 tx_cnt, tx_cnt_n;
    logic                       txd_r, txd_n;
    logic                       tx_load, tx_done;

    uart_bit_timer #(.W(TIMER_W)) u_tx_timer (
        .clk      (MCLK_IN),
        .rst      (RESET_IN),
        .load     (tx_load),
        .load_val (BIT_TICKS),
        .done     (tx_done)
    );

    // TX state and datapath registers; TXD is registered so reset forces it high at once.
    always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            tx_state <= TX_IDLE;
            tx_sh    <= '0;
            tx_cnt   <= '0;
            txd_r    <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_sh    <= tx_sh_n;
            tx_cnt   <= tx_cnt_n;
            txd_r    <= txd_n;
        end
    end

    // TX next state: each line level is held for one full bit timer interval.
    always_comb begin
        tx_state_n = tx_state;
        tx_sh_n    = tx_sh;
        tx_cnt_n   = tx_cnt;
        txd_n      = txd_r;
        tx_load    = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (trig_rise) begin
                    tx_state_n = TX_START;
                    tx_sh_n    = bus.UART_SEND_BYTE_IN;
                    txd_n      = 1'b0;
                    tx_load    = 1'b1;
                end
            end
            TX_START: begin
                if (tx_done) begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = '0;
                    txd_n      = tx_sh[0];
                    tx_load    = 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_done) begin
                    tx_load = 1'b1;
                    if (tx_cnt == LAST_BIT) begin
                        tx_state_n = TX_STOP;
                        txd_n      = 1'b1;
                    end else begin
                        tx_sh_n  = tx_sh >> 1;
                        txd_n    = tx_sh[1];
                        tx_cnt_n = tx_cnt + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_done) begin
                    // The edge that ends the stop bit may already start the next frame.
                    if (trig_rise) begin
                        tx_state_n = TX_START;
                        tx_sh_n    = bus.UART_SEND_BYTE_IN;
                        txd_n      = 1'b0;
                        tx_load    = 1'b1;
                    end else begin
                        tx_state_n = TX_IDLE;
                        txd_n      = 1'b1;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    assign bus.TXD            = txd_r;
    assign bus.UART_SEND_BUSY = (tx_state != TX_IDLE);

    // ---------------- receiver ----------------
    logic rx_s1, rx_s2;

    // Two-flop synchronizer for the asynchronous serial input (idles high).
    always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= bus.RXD_IN;
            rx_s2 <= rx_s1;
        end
    end

    rx_state_t                  rx_state, rx_state_n;
    logic [FRAME_DATA_BITS-1:0] rx_sh, rx_sh_n;
    logic [2:0]                 rx_cnt, rx_cnt_n;
    logic                       rx_load, rx_done, rx_good;
    logic [TIMER_W-1:0]         rx_load_val;

    uart_bit_timer #(.W(TIMER_W)) u_rx_timer (
        .clk      (MCLK_IN),
        .rst      (RESET_IN),
        .load     (rx_load),
        .load_val (rx_load_val),
        .done     (rx_done)
    );

    // RX state and shift register.
    always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            rx_state <= RX_IDLE;
            rx_sh    <= '0;
            rx_cnt   <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_sh    <= rx_sh_n;
            rx_cnt   <= rx_cnt_n;
        end
    end

    // RX next state: half a bit to the start-bit centre, then one bit per sample.
    always_comb begin
        rx_state_n  = rx_state;
        rx_sh_n     = rx_sh;
        rx_cnt_n    = rx_cnt;
        rx_load     = 1'b0;
        rx_load_val = BIT_TICKS;
        rx_good     = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_s2) begin
                    rx_state_n  = RX_START;
                    rx_load     = 1'b1;
                    rx_load_val = HALF_TICKS;
                end
            end
            RX_START: begin
                if (rx_done) begin
                    if (!rx_s2) begin
                        rx_state_n = RX_DATA;
                        rx_cnt_n   = '0;
                        rx_load    = 1'b1;
                    end else begin
                        rx_state_n = RX_IDLE;     // glitch, not a start bit
                    end
                end
            end
            RX_DATA: begin
                if (rx_done) begin
                    rx_sh_n  = {rx_s2, rx_sh[FRAME_DATA_BITS-1:1]};
                    rx_cnt_n = rx_cnt + 3'd1;
                    rx_load  = 1'b1;
                    if (rx_cnt == LAST_BIT)
                        rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_done) begin
                    rx_good    = rx_s2;           // stop=0 is a framing error: drop it
                    rx_state_n = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ---------------- holding register and flags ----------------
    logic [FRAME_DATA_BITS-1:0] hold;
    logic                       received, overrun;
    logic                       recv_eff, ovr_eff;

    // A capture falling edge clears first, so a frame completing on the same
    // edge lands in an empty register.
    assign recv_eff = received & ~cap_fall;
    assign ovr_eff  = overrun  & ~cap_fall;

    // Load a good frame into an empty register, or flag the loss if still full.
    always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            hold     <= '0;
            received <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            received <= recv_eff | rx_good;
            overrun  <= ovr_eff | (rx_good & recv_eff);
            if (rx_good && !recv_eff)
                hold <= rx_sh;
        end
    end

    assign bus.UART_RECEIVED     = received;
    assign bus.UART_OVERRUN      = overrun;
    assign bus.UART_RECEIVE_BYTE = hold;

endmodule
